// File: rtl/sysbus_rr_scheduler.sv
// Two-port Sysbus request arbiter with round-robin grant held per transaction,
// plus tag-matched response routing to the I-cache or D-cache.
module sysbus_rr_scheduler #(
    parameter int DATA_WIDTH = 64,
    parameter int TAG_WIDTH  = 13,
    parameter int WR_BEATS   = 8,
    parameter int RD_BEATS   = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] ireq,
    input  logic [TAG_WIDTH-1:0]  ireqtag,
    input  logic                  ireqcyc,
    output logic                  ireqack,
    input  logic [DATA_WIDTH-1:0] dreq,
    input  logic [TAG_WIDTH-1:0]  dreqtag,
    input  logic                  dreqcyc,
    output logic                  dreqack,
    output logic [DATA_WIDTH-1:0] iresp,
    output logic [TAG_WIDTH-1:0]  iresptag,
    output logic                  irespcyc,
    input  logic                  irespack,
    output logic [DATA_WIDTH-1:0] dresp,
    output logic [TAG_WIDTH-1:0]  dresptag,
    output logic                  drespcyc,
    input  logic                  drespack,
    output logic [DATA_WIDTH-1:0] bus_req,
    output logic [TAG_WIDTH-1:0]  bus_reqtag,
    output logic                  bus_reqcyc,
    input  logic                  bus_reqack,
    input  logic [DATA_WIDTH-1:0] bus_resp,
    input  logic [TAG_WIDTH-1:0]  bus_resptag,
    input  logic                  bus_respcyc,
    output logic                  bus_respack,
    output logic                  err_unmatched
);
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_HDR   = 2'd1;
    localparam logic [1:0] ST_WDATA = 2'd2;

    localparam logic PORT_I = 1'b0;
    localparam logic PORT_D = 1'b1;

    localparam logic [1:0] OWN_I    = 2'd0;
    localparam logic [1:0] OWN_D    = 2'd1;
    localparam logic [1:0] OWN_NONE = 2'd2;

    localparam int WCW = (WR_BEATS > 1) ? $clog2(WR_BEATS) : 1;
    localparam int RCW = (RD_BEATS > 1) ? $clog2(RD_BEATS) : 1;
    localparam logic [WCW-1:0] WLAST = WCW'(WR_BEATS - 1);
    localparam logic [RCW-1:0] RLAST = RCW'(RD_BEATS - 1);

    logic [1:0]           state;
    logic                 gnt;
    logic                 rr_last;
    logic [WCW-1:0]       wcnt;
    logic                 pend_i, pend_d;
    logic [TAG_WIDTH-1:0] tag_i, tag_d;
    logic                 rbusy;
    logic [1:0]           rown;
    logic [RCW-1:0]       rcnt;

    logic                 elig_i, elig_d, gnt_next;
    logic                 active, beat, hdr_read;
    logic                 set_i, set_d, clr_i, clr_d;
    logic [1:0]           own;
    logic                 rbeat, rlast;

    assign elig_i   = ireqcyc && !(ireqtag[TAG_WIDTH-1] && pend_i);
    assign elig_d   = dreqcyc && !(dreqtag[TAG_WIDTH-1] && pend_d);
    assign gnt_next = (elig_i && elig_d) ? ~rr_last : elig_d;
    assign active   = (state != ST_IDLE);

    always_comb begin
        bus_reqcyc = 1'b0;
        bus_req    = '0;
        bus_reqtag = '0;
        if (active) begin
            bus_reqcyc = (gnt == PORT_D) ? dreqcyc : ireqcyc;
            bus_req    = (gnt == PORT_D) ? dreq    : ireq;
            bus_reqtag = (gnt == PORT_D) ? dreqtag : ireqtag;
        end
    end

    assign beat     = bus_reqcyc && bus_reqack;
    assign ireqack  = beat && (gnt == PORT_I);
    assign dreqack  = beat && (gnt == PORT_D);
    assign hdr_read = bus_reqtag[TAG_WIDTH-1];
    assign set_i    = (state == ST_HDR) && ireqack && hdr_read;
    assign set_d    = (state == ST_HDR) && dreqack && hdr_read;

    // Owner is decided live until the first beat is consumed, then frozen for the burst.
    always_comb begin
        own = OWN_NONE;
        if (rbusy)                                    own = rown;
        else if (pend_i && (bus_resptag == tag_i))    own = OWN_I;
        else if (pend_d && (bus_resptag == tag_d))    own = OWN_D;
    end

    assign irespcyc    = bus_respcyc && (own == OWN_I);
    assign drespcyc    = bus_respcyc && (own == OWN_D);
    assign iresp       = bus_resp;
    assign dresp       = bus_resp;
    assign iresptag    = bus_resptag;
    assign dresptag    = bus_resptag;
    assign bus_respack = bus_respcyc &&
                         ((own == OWN_I) ? irespack : (own == OWN_D) ? drespack : 1'b1);
    assign rbeat       = bus_respcyc && bus_respack;
    assign rlast       = rbeat && (rcnt == RLAST);
    assign clr_i       = rlast && (own == OWN_I);
    assign clr_d       = rlast && (own == OWN_D);

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= ST_IDLE;
            gnt           <= PORT_I;
            rr_last       <= PORT_D;
            wcnt          <= '0;
            pend_i        <= 1'b0;
            pend_d        <= 1'b0;
            tag_i         <= '0;
            tag_d         <= '0;
            rbusy         <= 1'b0;
            rown          <= OWN_NONE;
            rcnt          <= '0;
            err_unmatched <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (elig_i || elig_d) begin
                        gnt     <= gnt_next;
                        rr_last <= gnt_next;
                        state   <= ST_HDR;
                    end
                end
                ST_HDR: begin
                    if (beat) begin
                        if (hdr_read) begin
                            state <= ST_IDLE;
                        end else begin
                            wcnt  <= '0;
                            state <= ST_WDATA;
                        end
                    end
                end
                ST_WDATA: begin
                    if (beat) begin
                        if (wcnt == WLAST) state <= ST_IDLE;
                        else               wcnt  <= wcnt + 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase

            // A new read header and the last response beat may land together: set wins.
            if (set_i) begin
                pend_i <= 1'b1;
                tag_i  <= bus_reqtag;
            end else if (clr_i) begin
                pend_i <= 1'b0;
            end
            if (set_d) begin
                pend_d <= 1'b1;
                tag_d  <= bus_reqtag;
            end else if (clr_d) begin
                pend_d <= 1'b0;
            end

            if (rbeat) begin
                if (rcnt == RLAST) begin
                    rbusy <= 1'b0;
                    rcnt  <= '0;
                end else begin
                    rbusy <= 1'b1;
                    rown  <= own;
                    rcnt  <= rcnt + 1'b1;
                end
                if (own == OWN_NONE) err_unmatched <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_sysbus_rr_scheduler.sv
// Bench for sysbus_rr_scheduler: caches and Sysbus are emulated here, and a
// transaction-level model predicts grant, acks, pending tags and response routing.
module tb_sysbus_rr_scheduler;
    localparam int DW = 64;
    localparam int TW = 13;
    localparam int WB = 8;
    localparam int RB = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic [DW-1:0] ireq, dreq, iresp, dresp, bus_req, bus_resp;
    logic [TW-1:0] ireqtag, dreqtag, iresptag, dresptag, bus_reqtag, bus_resptag;
    logic          ireqcyc, dreqcyc, ireqack, dreqack;
    logic          irespcyc, drespcyc, irespack, drespack;
    logic          bus_reqcyc, bus_reqack, bus_respcyc, bus_respack, err_unmatched;

    always #5 clk = ~clk;

    sysbus_rr_scheduler #(.DATA_WIDTH(DW), .TAG_WIDTH(TW), .WR_BEATS(WB), .RD_BEATS(RB)) dut (
        .clk(clk), .reset(reset),
        .ireq(ireq), .ireqtag(ireqtag), .ireqcyc(ireqcyc), .ireqack(ireqack),
        .dreq(dreq), .dreqtag(dreqtag), .dreqcyc(dreqcyc), .dreqack(dreqack),
        .iresp(iresp), .iresptag(iresptag), .irespcyc(irespcyc), .irespack(irespack),
        .dresp(dresp), .dresptag(dresptag), .drespcyc(drespcyc), .drespack(drespack),
        .bus_req(bus_req), .bus_reqtag(bus_reqtag), .bus_reqcyc(bus_reqcyc), .bus_reqack(bus_reqack),
        .bus_resp(bus_resp), .bus_resptag(bus_resptag), .bus_respcyc(bus_respcyc),
        .bus_respack(bus_respack), .err_unmatched(err_unmatched)
    );

    int errors = 0;
    int checks = 0;

    // Cache emulation: one outstanding transaction per port.
    bit            c_busy[2], c_data[2];
    logic [TW-1:0] c_tag[2];
    int            c_left[2];
    // Reference model: bus ownership, round robin, pending reads, response owner.
    int            m_own, m_left, m_last;
    bit            m_hdr, m_err;
    bit            m_pend[2];
    logic [TW-1:0] m_tag[2];
    bit            r_active;
    logic [TW-1:0] r_tag;
    int            r_cnt, r_own;
    int unsigned   start_pct, rsp_pct, gap_pct;
    int            obs_ack[2], obs_rbeat[2], obs_self, obs_rcyc;
    int            ack_log[$];

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic issue(input int p, input logic [TW-1:0] t);
        c_busy[p] = 1'b1;
        c_data[p] = 1'b0;
        c_tag[p]  = t;
        c_left[p] = t[TW-1] ? 1 : 1 + WB;
    endtask

    task automatic start_burst(input logic [TW-1:0] t);
        r_active = 1'b1;
        r_tag    = t;
        r_cnt    = 0;
    endtask

    task automatic pick_burst();
        logic [TW-1:0] t;
        int unsigned   ch;
        ch = $urandom_range(99);
        if (ch < 8) begin
            t = TW'($urandom);
            while ((m_pend[0] && t == m_tag[0]) || (m_pend[1] && t == m_tag[1])) t = t + 1'b1;
            start_burst(t);
        end else if (m_pend[0] && (!m_pend[1] || ch < 54)) begin
            start_burst(m_tag[0]);
        end else if (m_pend[1]) begin
            start_burst(m_tag[1]);
        end
    endtask

    task automatic reset_model();
        for (int p = 0; p < 2; p++) begin
            c_busy[p] = 1'b0; c_data[p] = 1'b0; c_tag[p] = '0; c_left[p] = 0;
            m_pend[p] = 1'b0; m_tag[p] = '0;
        end
        m_own = -1; m_left = 0; m_last = 1; m_hdr = 1'b0; m_err = 1'b0;
        r_active = 1'b0; r_tag = '0; r_cnt = 0; r_own = 2;
        ireqcyc = 1'b0; dreqcyc = 1'b0; ireq = '0; dreq = '0; ireqtag = '0; dreqtag = '0;
        irespack = 1'b0; drespack = 1'b0;
        bus_reqack = 1'b0; bus_respcyc = 1'b0; bus_resp = '0; bus_resptag = '0;
    endtask

    task automatic check_zero(input string pfx);
        check({pfx, "_bus_reqcyc"}, bus_reqcyc, 0);
        check({pfx, "_bus_req"}, bus_req, 0);
        check({pfx, "_bus_reqtag"}, bus_reqtag, 0);
        check({pfx, "_ireqack"}, ireqack, 0);
        check({pfx, "_dreqack"}, dreqack, 0);
        check({pfx, "_irespcyc"}, irespcyc, 0);
        check({pfx, "_drespcyc"}, drespcyc, 0);
        check({pfx, "_bus_respack"}, bus_respack, 0);
        check({pfx, "_err_unmatched"}, err_unmatched, 0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        reset_model();
        repeat (2) @(posedge clk);
        #1;
        check_zero("rst");
        reset = 1'b0;
    endtask

    // One clock: drive caches and bus, compare against the model, advance the model.
    task automatic step();
        bit            cyc[2];
        logic [DW-1:0] dat[2];
        logic [TW-1:0] t;
        bit            exp_cyc, exp_rack, acc, was_idle, e0, e1;
        int            own, g, set_p, clr_p;
        @(posedge clk);
        #1;
        for (int p = 0; p < 2; p++) begin
            if (!c_busy[p] && $urandom_range(99) < start_pct) begin
                t = TW'($urandom);
                issue(p, t);
            end
            cyc[p] = c_busy[p] && !(c_data[p] && $urandom_range(99) < gap_pct);
            dat[p] = {$urandom, $urandom};
        end
        if (!r_active && $urandom_range(99) < rsp_pct) pick_burst();
        ireqcyc = cyc[0]; ireqtag = c_tag[0]; ireq = dat[0];
        dreqcyc = cyc[1]; dreqtag = c_tag[1]; dreq = dat[1];
        irespack    = ($urandom_range(99) < 75);
        drespack    = ($urandom_range(99) < 75);
        bus_respcyc = r_active && ($urandom_range(99) < 85);
        bus_resptag = r_active ? r_tag : '0;
        bus_resp    = {$urandom, $urandom};
        exp_cyc     = (m_own >= 0) ? cyc[m_own] : 1'b0;
        bus_reqack  = exp_cyc && ($urandom_range(99) < 60);
        if (r_cnt > 0)                              own = r_own;
        else if (m_pend[0] && bus_resptag == m_tag[0]) own = 0;
        else if (m_pend[1] && bus_resptag == m_tag[1]) own = 1;
        else                                        own = 2;
        exp_rack = (own == 0) ? irespack : (own == 1) ? drespack : 1'b1;
        #1;
        check("bus_reqcyc", bus_reqcyc, exp_cyc);
        if (exp_cyc) begin
            check("bus_reqtag", bus_reqtag, c_tag[m_own]);
            check("bus_req", bus_req, dat[m_own]);
        end
        check("ireqack", ireqack, (m_own == 0) && bus_reqack);
        check("dreqack", dreqack, (m_own == 1) && bus_reqack);
        check("irespcyc", irespcyc, bus_respcyc && own == 0);
        check("drespcyc", drespcyc, bus_respcyc && own == 1);
        if (bus_respcyc) check("bus_respack", bus_respack, exp_rack);
        if (bus_respcyc && own == 0) check("iresp", {iresptag, iresp[DW-TW-1:0]}, {bus_resptag, bus_resp[DW-TW-1:0]});
        if (bus_respcyc && own == 1) check("dresp", {dresptag, dresp[DW-TW-1:0]}, {bus_resptag, bus_resp[DW-TW-1:0]});
        check("err_unmatched", err_unmatched, m_err);
        if (ireqack) begin obs_ack[0]++; ack_log.push_back(0); end
        if (dreqack) begin obs_ack[1]++; ack_log.push_back(1); end
        if (irespcyc && bus_respack) obs_rbeat[0]++;
        if (drespcyc && bus_respack) obs_rbeat[1]++;
        if (irespcyc || drespcyc) obs_rcyc++;
        if (bus_respcyc && bus_respack && !irespcyc && !drespcyc) obs_self++;

        acc = exp_cyc && bus_reqack;
        was_idle = (m_own < 0);
        set_p = -1;
        clr_p = -1;
        if (!was_idle && acc) begin
            if (m_hdr && c_tag[m_own][TW-1]) set_p = m_own;
            m_hdr = 1'b0;
            m_left--;
            c_data[m_own] = 1'b1;
            c_left[m_own]--;
            if (c_left[m_own] == 0) begin c_busy[m_own] = 1'b0; c_data[m_own] = 1'b0; end
            if (m_left == 0) m_own = -1;
        end else if (was_idle) begin
            e0 = cyc[0] && !(c_tag[0][TW-1] && m_pend[0]);
            e1 = cyc[1] && !(c_tag[1][TW-1] && m_pend[1]);
            if (e0 || e1) begin
                g = (e0 && e1) ? 1 - m_last : (e0 ? 0 : 1);
                m_own = g; m_last = g; m_hdr = 1'b1;
                m_left = c_tag[g][TW-1] ? 1 : 1 + WB;
            end
        end
        if (bus_respcyc && exp_rack) begin
            if (r_cnt == 0) begin
                r_own = own;
                if (own == 2) m_err = 1'b1;
            end
            r_cnt++;
            if (r_cnt == RB) begin
                if (own != 2) clr_p = own;
                r_active = 1'b0;
                r_cnt = 0;
            end
        end
        for (int p = 0; p < 2; p++) begin
            if (set_p == p) begin m_pend[p] = 1'b1; m_tag[p] = c_tag[p]; end
            else if (clr_p == p) m_pend[p] = 1'b0;
        end
    endtask

    function automatic bit cond(input int mode, input int arg);
        case (mode)
            0:       return !c_busy[arg];
            1:       return !r_active;
            2:       return obs_ack[1] >= arg;
            3:       return !c_busy[0] && !c_busy[1];
            default: return !c_busy[0] && !c_busy[1] && !r_active && !m_pend[0] && !m_pend[1];
        endcase
    endfunction

    task automatic wait_for(input string name, input int mode, input int arg, input int maxc);
        int n = 0;
        while (!cond(mode, arg) && n < maxc) begin
            step();
            n++;
        end
        check(name, cond(mode, arg), 1'b1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int a0, d0, b0, s0, q0;
        start_pct = 0; rsp_pct = 0; gap_pct = 0;
        for (int p = 0; p < 2; p++) begin obs_ack[p] = 0; obs_rbeat[p] = 0; end
        obs_self = 0; obs_rcyc = 0;
        do_reset();

        // I read 0x1A05, 8-beat response, pend cleared so a repeat read is granted
        issue(0, 13'h1A05);
        wait_for("t1_req", 0, 0, 50);
        b0 = obs_rbeat[0];
        start_burst(13'h1A05);
        wait_for("t1_rsp", 1, 0, 100);
        check("t1_ibeats", obs_rbeat[0] - b0, 8);
        issue(0, 13'h1A05);
        wait_for("t1_reissue", 0, 0, 50);
        start_burst(13'h1A05);
        wait_for("t1_rsp2", 1, 0, 100);

        // simultaneous ties from reset alternate I, D, I, D
        do_reset();
        ack_log.delete();
        for (int r = 0; r < 2; r++) begin
            issue(0, 13'h1100 + 13'(r));
            issue(1, 13'h1200 + 13'(r));
            wait_for("tie_req", 3, 0, 200);
            start_burst(13'h1100 + 13'(r));
            wait_for("tie_rsp_i", 1, 0, 100);
            start_burst(13'h1200 + 13'(r));
            wait_for("tie_rsp_d", 1, 0, 100);
        end
        check("tie_count", ack_log.size(), 4);
        for (int k = 0; k < 4 && k < ack_log.size(); k++) check("tie_order", ack_log[k], k % 2);

        // D write holds off an I read until the last data beat
        issue(1, 13'h0444);
        step();
        issue(0, 13'h1B00);
        a0 = obs_ack[0]; d0 = obs_ack[1];
        wait_for("wr_d", 0, 1, 300);
        check("wr_dack", obs_ack[1] - d0, 9);
        check("wr_i_held", obs_ack[0] - a0, 0);
        wait_for("wr_i", 0, 0, 100);
        check("wr_iack", obs_ack[0] - a0, 1);

        // second I read blocked by its pending read while D is served
        issue(0, 13'h1C00);
        issue(1, 13'h0555);
        a0 = obs_ack[0]; d0 = obs_ack[1];
        wait_for("pb_d", 0, 1, 300);
        check("pb_dack", obs_ack[1] - d0, 9);
        check("pb_i_blocked", obs_ack[0] - a0, 0);
        start_burst(13'h1B00);
        wait_for("pb_i", 0, 0, 300);
        check("pb_iack", obs_ack[0] - a0, 1);
        wait_for("pb_rsp", 1, 0, 100);

        // unmatched response is self-acked and flagged
        check("um_err_before", err_unmatched, 0);
        s0 = obs_self; q0 = obs_rcyc;
        start_burst(13'h0333);
        wait_for("um_rsp", 1, 0, 100);
        check("um_selfacks", obs_self - s0, 8);
        check("um_respcyc", obs_rcyc - q0, 0);
        check("um_err", err_unmatched, 1);

        // reset in the middle of a D write, with an I read pending
        do_reset();
        issue(0, 13'h1A05);
        wait_for("mr_i", 0, 0, 50);
        issue(1, 13'h0666);
        d0 = obs_ack[1];
        wait_for("mr_beat4", 2, d0 + 5, 300);
        reset = 1'b1;
        bus_reqack = 1'b0;
        bus_respcyc = 1'b0;
        @(posedge clk);
        #1;
        bus_reqack = 1'b1;
        #1;
        check_zero("mr");
        @(posedge clk);
        #1;
        reset = 1'b0;
        reset_model();
        issue(0, 13'h1A05);
        wait_for("mr_pend_cleared", 0, 0, 50);

        // randomized traffic, then drain
        do_reset();
        start_pct = 15; rsp_pct = 30; gap_pct = 20;
        repeat (3000) step();
        start_pct = 0;
        wait_for("drain", 4, 0, 3000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
